// File: rtl/cv32e40p_fpu_arb_pkg.sv
// Shared types and default widths for the FPU share arbiter.
package cv32e40p_fpu_arb_pkg;

  typedef enum logic [0:0] {IDLE, WAIT_GNT} fsm_e;

  // Index width, never below one bit so single-entry ranges stay legal
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NUM_REQ_DEF         = 4;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;
  localparam int unsigned ID_W                = idx_w(NUM_REQ_DEF);
  localparam int unsigned PTR_W               = idx_w(MAX_OUTSTANDING_DEF);

endpackage

// File: rtl/cv32e40p_fpu_arb_tag_fifo.sv
// In-order FIFO of requester IDs for operations issued to the shared FPU.
module cv32e40p_fpu_arb_tag_fifo
  import cv32e40p_fpu_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2 ** PTR_W,
  parameter int unsigned DATA_W = ID_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic [idx_w(DEPTH):0]         count
);

  localparam int unsigned AW = idx_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally; count is one bit wider to represent full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cv32e40p_fpu_share_arbiter.sv
// Round-robin sharing of one FPU among several cores, with in-order result routing.
module cv32e40p_fpu_share_arbiter
  import cv32e40p_fpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned APU_NARGS       = 3,
  parameter int unsigned APU_WOP         = 6,
  parameter int unsigned APU_NDSFLAGS    = 15,
  parameter int unsigned APU_NUSFLAGS    = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  input  logic [NUM_REQ*APU_WOP-1:0]        op_i,
  input  logic [NUM_REQ*APU_NARGS*32-1:0]   operands_i,
  input  logic [NUM_REQ*APU_NDSFLAGS-1:0]   flags_i,
  output logic [NUM_REQ-1:0]                rvalid_o,
  output logic [31:0]                       result_o,
  output logic [APU_NUSFLAGS-1:0]           rflags_o,
  output logic                              fpu_req_o,
  input  logic                              fpu_gnt_i,
  output logic [APU_WOP-1:0]                fpu_op_o,
  output logic [APU_NARGS*32-1:0]           fpu_operands_o,
  output logic [APU_NDSFLAGS-1:0]           fpu_flags_o,
  input  logic                              fpu_rvalid_i,
  input  logic [31:0]                       fpu_result_i,
  input  logic [APU_NUSFLAGS-1:0]           fpu_rflags_i,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int unsigned SEL_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = idx_w(MAX_OUTSTANDING) + 1;
  localparam int unsigned OPS_W = APU_NARGS * 32;

  fsm_e             state, state_nxt;
  logic [SEL_W-1:0] prio_ptr, locked_id, winner, sel, head;
  logic             hs, bypass, push, pop, full, empty, err_set;
  logic [CNT_W-1:0] count;
  int unsigned      idx;
  logic             found;

  logic [APU_WOP-1:0]      op_arr    [NUM_REQ];
  logic [OPS_W-1:0]        opnd_arr  [NUM_REQ];
  logic [APU_NDSFLAGS-1:0] flags_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]    = op_i[g*APU_WOP +: APU_WOP];
    assign opnd_arr[g]  = operands_i[g*OPS_W +: OPS_W];
    assign flags_arr[g] = flags_i[g*APU_NDSFLAGS +: APU_NDSFLAGS];
  end

  // First asserted request at or after the priority pointer, cyclic scan
  always_comb begin
    winner = prio_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(prio_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[SEL_W'(idx)]) begin
        winner = SEL_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign sel       = (state == WAIT_GNT) ? locked_id : winner;
  assign fpu_req_o = (state == WAIT_GNT) ? 1'b1 : ((|req_i) & ~full);
  assign hs        = fpu_req_o & fpu_gnt_i;
  assign bypass    = hs & fpu_rvalid_i & empty;
  assign push      = hs & ~bypass;
  assign pop       = fpu_rvalid_i & ~empty;

  assign fpu_op_o       = op_arr[sel];
  assign fpu_operands_o = opnd_arr[sel];
  assign fpu_flags_o    = flags_arr[sel];

  assign gnt_o    = hs ? (NUM_REQ'(1) << sel) : '0;
  assign rvalid_o = bypass ? (NUM_REQ'(1) << sel) :
                    pop    ? (NUM_REQ'(1) << head) : '0;
  assign result_o = fpu_result_i;
  assign rflags_o = fpu_rflags_i;
  assign busy_o   = (count != '0) | (state == WAIT_GNT);

  always_comb begin
    state_nxt = state;
    err_set   = fpu_rvalid_i & empty & ~hs;
    case (state)
      IDLE:     if (fpu_req_o && !fpu_gnt_i) state_nxt = WAIT_GNT;
      WAIT_GNT: begin
        if (!req_i[locked_id]) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else if (fpu_gnt_i) begin
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      locked_id <= '0;
      err_o     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fpu_req_o && !fpu_gnt_i) locked_id <= winner;
      if (hs) prio_ptr <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + SEL_W'(1);
      if (err_set) err_o <= 1'b1;
    end
  end

  cv32e40p_fpu_arb_tag_fifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (SEL_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (sel),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_cv32e40p_fpu_share_arbiter.sv
// Directed self-checking bench for the FPU share arbiter.
module tb_cv32e40p_fpu_share_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned MO  = 4;
  localparam int unsigned NA  = 3;
  localparam int unsigned WOP = 6;
  localparam int unsigned NDS = 15;
  localparam int unsigned NUS = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_i;
  logic [NR-1:0]     gnt_o;
  logic [NR*WOP-1:0] op_i;
  logic [NR*NA*32-1:0] operands_i;
  logic [NR*NDS-1:0] flags_i;
  logic [NR-1:0]     rvalid_o;
  logic [31:0]       result_o;
  logic [NUS-1:0]    rflags_o;
  logic              fpu_req_o;
  logic              fpu_gnt_i;
  logic [WOP-1:0]    fpu_op_o;
  logic [NA*32-1:0]  fpu_operands_o;
  logic [NDS-1:0]    fpu_flags_o;
  logic              fpu_rvalid_i;
  logic [31:0]       fpu_result_i;
  logic [NUS-1:0]    fpu_rflags_i;
  logic              busy_o;
  logic              err_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cv32e40p_fpu_share_arbiter #(
    .NUM_REQ(NR), .MAX_OUTSTANDING(MO), .APU_NARGS(NA),
    .APU_WOP(WOP), .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .op_i(op_i),
    .operands_i(operands_i), .flags_i(flags_i), .rvalid_o(rvalid_o),
    .result_o(result_o), .rflags_o(rflags_o), .fpu_req_o(fpu_req_o),
    .fpu_gnt_i(fpu_gnt_i), .fpu_op_o(fpu_op_o), .fpu_operands_o(fpu_operands_o),
    .fpu_flags_o(fpu_flags_o), .fpu_rvalid_i(fpu_rvalid_i),
    .fpu_result_i(fpu_result_i), .fpu_rflags_i(fpu_rflags_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  function automatic logic [WOP-1:0] exp_op(input int k);
    return WOP'(6'h20 + k);
  endfunction

  function automatic logic [NA*32-1:0] exp_opnd(input int k);
    logic [NA*32-1:0] v;
    for (int j = 0; j < NA; j++) v[j*32 +: 32] = 32'hA000_0000 | 32'(k << 8) | 32'(j);
    return v;
  endfunction

  function automatic logic [NDS-1:0] exp_flags(input int k);
    return NDS'(15'h4000 + k);
  endfunction

  task automatic idle_inputs();
    req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b0;
    fpu_result_i = '0; fpu_rflags_i = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    n_checks++; if (gnt_o !== '0) $display("FAIL reset_gnt got %b want 0000", gnt_o); else n_pass++;
    n_checks++; if (rvalid_o !== '0) $display("FAIL reset_rvalid got %b want 0000", rvalid_o); else n_pass++;
    n_checks++; if (fpu_req_o !== 1'b0) $display("FAIL reset_fpu_req got %b want 0", fpu_req_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_grant_latency();
    reset_dut();
    req_i = 4'b0001; fpu_gnt_i = 1'b1;
    #1;
    n_checks++; if (gnt_o !== 4'b0001) $display("FAIL lat_gnt got %b want 0001", gnt_o); else n_pass++;
    n_checks++; if (fpu_op_o !== exp_op(0)) $display("FAIL lat_op got %h want %h", fpu_op_o, exp_op(0)); else n_pass++;
    n_checks++; if (fpu_operands_o !== exp_opnd(0)) $display("FAIL lat_opnd got %h want %h", fpu_operands_o, exp_opnd(0)); else n_pass++;
    n_checks++; if (fpu_flags_o !== exp_flags(0)) $display("FAIL lat_flags got %h want %h", fpu_flags_o, exp_flags(0)); else n_pass++;
    @(negedge clk);
    req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b1;
    fpu_result_i = 32'h3F80_0000; fpu_rflags_i = 5'h03;
    #1;
    n_checks++; if (rvalid_o !== 4'b0001) $display("FAIL lat_rvalid got %b want 0001", rvalid_o); else n_pass++;
    n_checks++; if (result_o !== 32'h3F80_0000) $display("FAIL lat_result got %h want 3f800000", result_o); else n_pass++;
    n_checks++; if (rflags_o !== 5'h03) $display("FAIL lat_rflags got %h want 03", rflags_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL lat_busy got %b want 1", busy_o); else n_pass++;
    @(negedge clk);
    fpu_rvalid_i = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL lat_idle_busy got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [6];
    logic [NR-1:0] exp_r [6];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    exp_r = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      req_i        = (c < 5) ? 4'b1111 : 4'b0000;
      fpu_gnt_i    = (c < 5);
      fpu_rvalid_i = (c > 0);
      fpu_result_i = 32'h1000 + 32'(c);
      #1;
      n_checks++; if (gnt_o !== exp_g[c]) $display("FAIL rr_gnt[%0d] got %b want %b", c, gnt_o, exp_g[c]); else n_pass++;
      n_checks++; if (rvalid_o !== exp_r[c]) $display("FAIL rr_rvalid[%0d] got %b want %b", c, rvalid_o, exp_r[c]); else n_pass++;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_stall_lock();
    reset_dut();
    req_i = 4'b0010; fpu_gnt_i = 1'b0;
    #1;
    n_checks++; if (fpu_req_o !== 1'b1) $display("FAIL lock_req got %b want 1", fpu_req_o); else n_pass++;
    @(negedge clk);
    req_i = 4'b0110;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (fpu_op_o !== exp_op(1)) $display("FAIL lock_op[%0d] got %h want %h", c, fpu_op_o, exp_op(1)); else n_pass++;
      n_checks++; if (gnt_o !== 4'b0000) $display("FAIL lock_nognt[%0d] got %b want 0000", c, gnt_o); else n_pass++;
      @(negedge clk);
    end
    fpu_gnt_i = 1'b1;
    #1;
    n_checks++; if (gnt_o !== 4'b0010) $display("FAIL lock_gnt got %b want 0010", gnt_o); else n_pass++;
    n_checks++; if (fpu_operands_o !== exp_opnd(1)) $display("FAIL lock_opnd got %h want %h", fpu_operands_o, exp_opnd(1)); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (gnt_o !== 4'b0100) $display("FAIL lock_next_gnt got %b want 0100", gnt_o); else n_pass++;
    @(negedge clk);
    req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b1;
    #1;
    n_checks++; if (rvalid_o !== 4'b0010) $display("FAIL lock_ret0 got %b want 0010", rvalid_o); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (rvalid_o !== 4'b0100) $display("FAIL lock_ret1 got %b want 0100", rvalid_o); else n_pass++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic [NR-1:0] exp_r [4];
    exp_r = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_dut();
    req_i = 4'b1111; fpu_gnt_i = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (fpu_req_o !== 1'b0) $display("FAIL full_req got %b want 0", fpu_req_o); else n_pass++;
    n_checks++; if (gnt_o !== 4'b0000) $display("FAIL full_gnt got %b want 0000", gnt_o); else n_pass++;
    @(negedge clk);
    fpu_rvalid_i = 1'b1;
    #1;
    n_checks++; if (fpu_req_o !== 1'b0) $display("FAIL full_nobypass got %b want 0", fpu_req_o); else n_pass++;
    n_checks++; if (rvalid_o !== 4'b0001) $display("FAIL full_pop got %b want 0001", rvalid_o); else n_pass++;
    @(negedge clk);
    fpu_rvalid_i = 1'b0;
    #1;
    n_checks++; if (gnt_o !== 4'b0001) $display("FAIL full_regnt got %b want 0001", gnt_o); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (fpu_req_o !== 1'b0) $display("FAIL full_again got %b want 0", fpu_req_o); else n_pass++;
    req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (rvalid_o !== exp_r[c]) $display("FAIL full_drain[%0d] got %b want %b", c, rvalid_o, exp_r[c]); else n_pass++;
      @(negedge clk);
    end
    fpu_rvalid_i = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL full_busy got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_bypass();
    reset_dut();
    req_i = 4'b0100; fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b1;
    fpu_result_i = 32'h4049_0FDB; fpu_rflags_i = 5'h11;
    #1;
    n_checks++; if (gnt_o !== 4'b0100) $display("FAIL byp_gnt got %b want 0100", gnt_o); else n_pass++;
    n_checks++; if (rvalid_o !== 4'b0100) $display("FAIL byp_rvalid got %b want 0100", rvalid_o); else n_pass++;
    n_checks++; if (result_o !== 32'h4049_0FDB) $display("FAIL byp_result got %h want 40490fdb", result_o); else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL byp_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL byp_err got %b want 0", err_o); else n_pass++;
  endtask

  task automatic test_protocol_errors();
    reset_dut();
    fpu_rvalid_i = 1'b1; fpu_result_i = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (rvalid_o !== 4'b0000) $display("FAIL err_drop got %b want 0000", rvalid_o); else n_pass++;
    @(negedge clk);
    fpu_rvalid_i = 1'b0;
    #1;
    n_checks++; if (err_o !== 1'b1) $display("FAIL err_set got %b want 1", err_o); else n_pass++;
    req_i = 4'b0001; fpu_gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    req_i = '0; fpu_gnt_i = 1'b0;
    #1;
    n_checks++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", err_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL err_busy3 got %b want 1", busy_o); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err got %b want 0", err_o); else n_pass++;
    req_i = 4'b0010;
    @(negedge clk);
    req_i = '0;
    #1;
    n_checks++; if (err_o !== 1'b0) $display("FAIL drop_early got %b want 0", err_o); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (err_o !== 1'b1) $display("FAIL drop_err got %b want 1", err_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL drop_busy got %b want 0", busy_o); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin
      op_i[k*WOP +: WOP]         = exp_op(k);
      operands_i[k*NA*32 +: NA*32] = exp_opnd(k);
      flags_i[k*NDS +: NDS]      = exp_flags(k);
    end
    test_reset();
    test_grant_latency();
    test_round_robin();
    test_stall_lock();
    test_fifo_full();
    test_bypass();
    test_protocol_errors();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_fpu_share_arbiter.md
Name: cv32e40p_fpu_share_arbiter

Overview:
Shares one FPU instance among NUM_REQ cores over the APU request/grant/rvalid protocol. It round-robin arbitrates requests, holds the arbitration lock while the FPU stalls, and tracks outstanding operations in a tag FIFO so each in-order result returns to its issuing core. It sits between the cores' APU ports and a single FPU wrapper, and supports zero-latency configurations (FPU_ADDMUL_LAT = 0, FPU_OTHERS_LAT = 0).

Parameters:
- NUM_REQ, 4: number of requesting cores; 2..8.
- MAX_OUTSTANDING, 4: tag FIFO depth; power of two, at least 2.
- APU_NARGS, 3: operands per op.
- APU_WOP, 6: op field width.
- APU_NDSFLAGS, 15: downstream flags width.
- APU_NUSFLAGS, 5: upstream flags width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_i  in  NUM_REQ  per-core request
- gnt_o  out  NUM_REQ  per-core grant
- op_i  in  NUM_REQ*APU_WOP  per-core op
- operands_i  in  NUM_REQ*APU_NARGS*32  per-core operands
- flags_i  in  NUM_REQ*APU_NDSFLAGS  per-core flags
- rvalid_o  out  NUM_REQ  per-core result valid
- result_o  out  32  result, broadcast to all cores
- rflags_o  out  APU_NUSFLAGS  result flags, broadcast
- fpu_req_o  out  1  FPU request
- fpu_gnt_i  in  1  FPU grant
- fpu_op_o  out  APU_WOP  muxed op
- fpu_operands_o  out  APU_NARGS*32  muxed operands
- fpu_flags_o  out  APU_NDSFLAGS  muxed flags
- fpu_rvalid_i  in  1  FPU result valid (results return in issue order)
- fpu_result_i  in  32  FPU result
- fpu_rflags_i  in  APU_NUSFLAGS  FPU result flags
- busy_o  out  1  set when outstanding count is non-zero or a request is locked
- err_o  out  1  sticky protocol error

Behaviour:
- Reset state:
  - FSM in IDLE; priority pointer = 0; FIFO count, read and write pointers = 0; err_o = 0.
  - All outputs driven 0: gnt_o, rvalid_o, fpu_req_o, busy_o.
- FSM states: IDLE and WAIT_GNT.
- IDLE:
  - The winner is the first asserted req_i at or after the priority pointer, scanning cyclically.
  - fpu_req_o = |req_i AND count < MAX_OUTSTANDING. A full FIFO blocks issue; there is no same-cycle pop bypass.
  - If fpu_req_o = 1 and fpu_gnt_i = 0: register the winner as locked_id and go to WAIT_GNT.
- WAIT_GNT:
  - The mux selects locked_id; fpu_req_o = 1; no re-arbitration.
  - Requesters must hold req_i and payload stable until granted. If req_i[locked_id] drops, set err_o and return to IDLE.
  - On fpu_gnt_i go to IDLE.
- Handshake (fpu_req_o AND fpu_gnt_i):
  - gnt_o[sel] = 1, combinational in the same cycle.
  - Priority pointer becomes sel+1 mod NUM_REQ.
  - sel is pushed into the tag FIFO.
- Result return:
  - On fpu_rvalid_i, pop the FIFO head and assert rvalid_o[head] in the same cycle.
  - result_o and rflags_o pass through combinationally.
- Zero-latency bypass: if fpu_rvalid_i coincides with a handshake while the FIFO is empty, assert rvalid_o[sel] directly with no push and no pop.
- Simultaneous push and pop with a non-empty FIFO: count is unchanged and both pointers advance.
- Error handling: fpu_rvalid_i with an empty FIFO and no same-cycle handshake sets err_o and the result is dropped. err_o clears only on reset.
- Pointer wrap: pointers are log2(MAX_OUTSTANDING) bits wide and wrap naturally. Count is one bit wider.
- At most one rvalid_o bit is high per cycle.
- Reset mid-operation flushes all state. The FPU must be reset together with this block.

Decomposition:
- Package cv32e40p_fpu_arb_pkg holds:
  - typedef fsm_e {IDLE, WAIT_GNT};
  - localparam widths derived from the parameters (ID_W = $clog2(NUM_REQ), PTR_W).
- Sub-module cv32e40p_fpu_arb_tag_fifo: synchronous FIFO of requester IDs with push, pop, full, empty and count.

Test Plan:
- Grant latency: req_i=0001, fpu_gnt_i=1, FPU latency 1 → gnt_o=0001 in the same cycle; the next cycle, fpu_rvalid_i with result 0x3F800000 → rvalid_o=0001, result_o=0x3F800000.
- Round-robin order: req_i=1111 held, fpu_gnt_i=1 every cycle → grants 0001, 0010, 0100, 1000, 0001; results return to cores 0, 1, 2, 3 in that order.
- Stall lock: fpu_gnt_i low for 3 cycles while req_i changes from 0010 to 0110 → fpu_op_o stays core 1's op and gnt_o=0010 when the FPU grants.
- FIFO full: MAX_OUTSTANDING=4, four grants with no rvalid → fpu_req_o=0 and gnt_o=0; one rvalid → fpu_req_o=1 the next cycle, count stays 4 after the next grant.
- Zero-latency bypass: FIFO empty, fpu_gnt_i and fpu_rvalid_i both high with req_i=0100 → rvalid_o=0100 in the same cycle, count stays 0, err_o=0.
- Protocol errors: fpu_rvalid_i with an empty FIFO → err_o=1 and stays 1 until rst_n=0. A reset with 3 ops outstanding → count=0 and busy_o=0 the cycle after.
